traffic_ctrl: RTL and testbench
===============================

// Module: traffic_ctrl
// PURPOSE
//  Phase sequencer for a two-way (NS/EW) intersection, directly upstream of the timer block.
//  Per phase: issues t_start and t_length to the timer, then advances on the timer's t_done.
//  Drives the NS/EW lamp outputs and, optionally, a pedestrian walk lamp that flickers on t_flicker.
// PARAMETERS
//  GREEN_LEN   20  timer ticks for a green phase; legal range 1..31
//  YELLOW_LEN  4   timer ticks for a yellow phase; legal range 1..31
//  RED_LEN     2   timer ticks for an all-red clearance phase; legal range 1..31
//  WALK_LEN    10  timer ticks for the pedestrian walk phase; legal range 6..31 (checked only if PED_WALK_EN)
//  Any value outside its range -> $error at elaboration.
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset_n      in   1  asynchronous, active-low reset
//  ped_btn      in   1  pedestrian request, level; synchronous to clk
//  t_done       in   1  from timer: current phase time elapsed
//  t_flicker    in   1  from timer: in last ticks of current phase
//  t_start      out  1  to timer: one-cycle pulse restarting its count
//  t_length     out  5  to timer: length of current phase, stable for the whole phase
//  ns_light     out  3  {red,yellow,green}, exactly one bit high
//  ew_light     out  3  {red,yellow,green}, exactly one bit high
//  walk         out  1  pedestrian walk lamp
//  walk_flicker out  1  walk lamp blink enable
//  state_o      out  3  current state encoding, for debug
// BEHAVIOUR
//  States and encodings:
//    RED_A=0, NS_GRN=1, NS_YEL=2, RED_B=3, EW_GRN=4, EW_YEL=5, PED_WALK=6.
//  Cycle: RED_A -> NS_GRN -> NS_YEL -> RED_B -> EW_GRN -> EW_YEL -> RED_A.
//  t_length is a combinational decode of state:
//    RED_*    -> RED_LEN
//    *_GRN    -> GREEN_LEN
//    *_YEL    -> YELLOW_LEN
//    PED_WALK -> WALK_LEN
//  t_start is a register:
//    - reset value 1, so the first cycle after reset release starts the timer;
//    - set to 1 on every state transition, so it is high exactly during the first cycle of each state;
//    - 0 otherwise.
//  Advance rule: leave the current state when t_done=1 && t_start=0.
//    - t_done is ignored in a state's first cycle, because the timer still shows the previous phase's done.
//    - Dwell in every state is therefore exactly L+1 cycles (L = t_length): 1 start cycle + L count cycles.
//  Lamps:
//    - ns_light=GREEN only in NS_GRN and YELLOW only in NS_YEL; all other states RED.
//    - ew_light follows the same rule with EW_GRN/EW_YEL.
//    - Both are RED in RED_A, RED_B and PED_WALK.
//  Reset values:
//    state=RED_A, t_start=1, t_length=RED_LEN, ns_light=ew_light=3'b100, walk=0, walk_flicker=0, state_o=0.
//  Reset mid-phase: lamps return to all-red immediately (async) and the sequence restarts at RED_A.
//  Never both directions non-red in the same cycle; assertion provided in RTL.
// CONFIGURATION
//  Macro PED_WALK_EN.
//  Defined:
//    - ped_req flag, reset 0, set by ped_btn=1 in any state except PED_WALK.
//    - Exit from EW_YEL goes to PED_WALK if ped_req=1 (including a ped_btn=1 in that same cycle); otherwise RED_A.
//    - PED_WALK -> RED_A on the advance rule. ped_req is cleared on entry to PED_WALK.
//    - walk=1 throughout PED_WALK.
//    - walk_flicker = walk & t_flicker & ~t_start: high for the last 6 cycles of PED_WALK.
//  Undefined:
//    - ped_btn is ignored, PED_WALK is unreachable, walk=walk_flicker=0 constantly.
// TESTING (bench instantiates the timer; its active-high reset = ~reset_n; defaults)
//  1. Release reset, hold ped_btn=0 -> t_start high in cycle 0.
//     -> RED_A lasts 3 cycles, NS_GRN 21, NS_YEL 5, RED_B 3, EW_GRN 21, EW_YEL 5, then RED_A again.
//  2. Every state entry -> t_start high for exactly 1 cycle with t_length already at the new value.
//     -> No t_start in any other cycle.
//  3. Pulse ped_btn for 1 cycle during NS_GRN (PED_WALK_EN defined).
//     -> EW_YEL is followed by PED_WALK for 11 cycles, walk=1, walk_flicker=1 in its last 6 cycles.
//     -> Then RED_A, with ped_req cleared.
//  4. Same stimulus with PED_WALK_EN undefined -> EW_YEL goes to RED_A; walk and walk_flicker stay 0.
//  5. Assert reset_n=0 in the 10th cycle of EW_GRN.
//     -> Same cycle: ns_light=ew_light=3'b100 and state_o=0.
//     -> After release, the sequence of test 1 repeats exactly.
//  6. Hold ped_btn=1 throughout PED_WALK -> no re-latch.
//     -> Next cycle: RED_A, NS_GRN, …, EW_YEL, RED_A (no walk), unless pressed again.

Source files
------------

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: NS/EW intersection phase sequencer driving an external phase timer.
// Optional pedestrian walk phase after EW_YEL is enabled by defining PED_WALK_EN.
module traffic_ctrl #(
   parameter int GREEN_LEN  = 20,
   parameter int YELLOW_LEN = 4,
   parameter int RED_LEN    = 2,
   parameter int WALK_LEN   = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ped_btn,
   input  logic       t_done,
   input  logic       t_flicker,
   output logic       t_start,
   output logic [4:0] t_length,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic       walk_flicker,
   output logic [2:0] state_o
);
   localparam logic [2:0] RED_A    = 3'd0;
   localparam logic [2:0] NS_GRN   = 3'd1;
   localparam logic [2:0] NS_YEL   = 3'd2;
   localparam logic [2:0] RED_B    = 3'd3;
   localparam logic [2:0] EW_GRN   = 3'd4;
   localparam logic [2:0] EW_YEL   = 3'd5;
   localparam logic [2:0] PED_WALK = 3'd6;

   if (GREEN_LEN < 1 || GREEN_LEN > 31) begin : g_bad_green
      $error("traffic_ctrl: GREEN_LEN out of range 1..31");
   end
   if (YELLOW_LEN < 1 || YELLOW_LEN > 31) begin : g_bad_yellow
      $error("traffic_ctrl: YELLOW_LEN out of range 1..31");
   end
   if (RED_LEN < 1 || RED_LEN > 31) begin : g_bad_red
      $error("traffic_ctrl: RED_LEN out of range 1..31");
   end
`ifdef PED_WALK_EN
   if (WALK_LEN < 6 || WALK_LEN > 31) begin : g_bad_walk
      $error("traffic_ctrl: WALK_LEN out of range 6..31");
   end
`endif

   logic [2:0] state, next_state;
   logic       adv, ped_go;

   // the timer still shows the previous phase's done during a start cycle
   assign adv = t_done & ~t_start;

   always_comb
      next_state = !adv            ? state  :
                   state == RED_A  ? NS_GRN :
                   state == NS_GRN ? NS_YEL :
                   state == NS_YEL ? RED_B  :
                   state == RED_B  ? EW_GRN :
                   state == EW_GRN ? EW_YEL :
                   state == EW_YEL ? (ped_go ? PED_WALK : RED_A) :
                   RED_A;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state   <= RED_A;
         t_start <= 1'b1;
      end else begin
         state   <= next_state;
         t_start <= next_state != state;
      end

   assign t_length = (state == NS_GRN || state == EW_GRN) ? 5'(GREEN_LEN)  :
                     (state == NS_YEL || state == EW_YEL) ? 5'(YELLOW_LEN) :
                     state == PED_WALK                    ? 5'(WALK_LEN)   :
                     5'(RED_LEN);

   assign ns_light = state == NS_GRN ? 3'b001 : state == NS_YEL ? 3'b010 : 3'b100;
   assign ew_light = state == EW_GRN ? 3'b001 : state == EW_YEL ? 3'b010 : 3'b100;
   assign state_o  = state;

`ifdef PED_WALK_EN
   logic ped_req;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ped_req <= 1'b0;
      else ped_req <= (state != PED_WALK && next_state == PED_WALK) ? 1'b0 :
                      (state != PED_WALK && ped_btn) ? 1'b1 : ped_req;
   assign ped_go       = ped_req | ped_btn;
   assign walk         = state == PED_WALK;
   assign walk_flicker = walk & t_flicker & ~t_start;
`else
   logic unused_in;
   assign unused_in    = ^{ped_btn, t_flicker};
   assign ped_go       = 1'b0;
   assign walk         = 1'b0;
   assign walk_flicker = 1'b0;
`endif

   a_no_conflict: assert property (@(posedge clk) disable iff (!reset_n)
      !(ns_light != 3'b100 && ew_light != 3'b100));
endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: scoreboard bench for traffic_ctrl with a behavioural phase timer.
// Walk-phase expectations follow PED_WALK_EN as defined for the build.
module tb_traffic_ctrl;
   logic       clk = 1'b0, reset_n = 1'b0, ped_btn = 1'b0;
   logic       t_done, t_flicker, t_start, walk, walk_flicker, timer_rst;
   logic [4:0] t_length, cnt;
   logic [2:0] ns_light, ew_light, state_o;
   int         total = 0, bad = 0, cyc = 0;

   typedef struct packed {
      logic [2:0] st;
      logic       ts;
      logic [4:0] len;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       wk;
      logic       wf;
   } obs_t;
   obs_t q[$];

   traffic_ctrl dut (
      .clk(clk), .reset_n(reset_n), .ped_btn(ped_btn), .t_done(t_done),
      .t_flicker(t_flicker), .t_start(t_start), .t_length(t_length),
      .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
      .walk_flicker(walk_flicker), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // timer: t_start loads 1, then counts up to t_length and holds
   assign timer_rst = ~reset_n;
   always @(posedge clk or posedge timer_rst)
      if (timer_rst) cnt <= 5'd0;
      else if (t_start) cnt <= 5'd1;
      else if (cnt < t_length) cnt <= cnt + 5'd1;
   assign t_done    = cnt == t_length;
   assign t_flicker = int'(cnt) + 6 > int'(t_length);

   function automatic obs_t expect_of(input logic [2:0] st, input int i, input int n);
      obs_t e;
      e.st  = st;
      e.ts  = (i == 0);
      e.len = (st == 3'd1 || st == 3'd4) ? 5'd20 : (st == 3'd2 || st == 3'd5) ? 5'd4 :
              (st == 3'd6) ? 5'd10 : 5'd2;
      e.ns  = st == 3'd1 ? 3'b001 : st == 3'd2 ? 3'b010 : 3'b100;
      e.ew  = st == 3'd4 ? 3'b001 : st == 3'd5 ? 3'b010 : 3'b100;
      e.wk  = st == 3'd6;
      e.wf  = st == 3'd6 && i >= n - 6;
      return e;
   endfunction

   task automatic phase(input logic [2:0] st, input int n, input int press_at, input bit hold);
      obs_t e, a;
      for (int i = 0; i < n; i++) begin
         ped_btn = hold || i == press_at;
         q.push_back(expect_of(st, i, n));
         @(negedge clk);
         a = {state_o, t_start, t_length, ns_light, ew_light, walk, walk_flicker};
         e = q.pop_front();
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL phase cyc=%0d st=%0d i=%0d actual=%h required=%h", cyc, st, i, a, e);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic full_cycle(input int press_at);
      phase(3'd0, 3, -1, 1'b0);
      phase(3'd1, 21, press_at, 1'b0);
      phase(3'd2, 5, -1, 1'b0);
      phase(3'd3, 3, -1, 1'b0);
      phase(3'd4, 21, -1, 1'b0);
      phase(3'd5, 5, -1, 1'b0);
   endtask

   task automatic test_reset();
      obs_t a;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a = {state_o, t_start, t_length, ns_light, ew_light, walk, walk_flicker};
      total++;
      if (a !== {3'd0, 1'b1, 5'd2, 3'b100, 3'b100, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset actual=%h required=%h", a, {3'd0, 1'b1, 5'd2, 3'b100, 3'b100, 2'b00});
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_cycle();
      full_cycle(-1);
   endtask

   task automatic test_ped();
      full_cycle(5);
`ifdef PED_WALK_EN
      phase(3'd6, 11, -1, 1'b0);
`endif
      full_cycle(-1);
   endtask

   task automatic test_hold();
      full_cycle(3);
`ifdef PED_WALK_EN
      phase(3'd6, 11, -1, 1'b1);
`endif
      full_cycle(-1);
   endtask

   task automatic test_reset_mid();
      logic [8:0] a;
      phase(3'd0, 3, -1, 1'b0);
      phase(3'd1, 21, -1, 1'b0);
      phase(3'd2, 5, -1, 1'b0);
      phase(3'd3, 3, -1, 1'b0);
      phase(3'd4, 9, -1, 1'b0);
      reset_n = 1'b0;
      #1;
      a = {state_o, ns_light, ew_light};
      total++;
      if (a !== {3'd0, 3'b100, 3'b100}) begin
         bad++;
         $display("FAIL reset_mid actual=%h required=%h", a, {3'd0, 3'b100, 3'b100});
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      full_cycle(-1);
   endtask

   task automatic test_back_to_back();
      full_cycle(0);
`ifdef PED_WALK_EN
      phase(3'd6, 11, -1, 1'b0);
`endif
      full_cycle(20);
`ifdef PED_WALK_EN
      phase(3'd6, 11, -1, 1'b0);
`endif
      phase(3'd0, 3, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_cycle();
      test_ped();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
